// File: rtl/gpio_in_cond.sv
// gpio_in_cond: pad input sync, optional debounce and per-bit irq detect.
// Debounce counters are compiled in only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_cond #(
    parameter int WIDTH    = 24,
    parameter int DB_CNT_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [WIDTH-1:0]    i_gpio,
    input  logic [WIDTH-1:0]    db_en,
    input  logic [DB_CNT_W-1:0] db_limit,
    input  logic [WIDTH-1:0]    irq_en,
    input  logic [WIDTH-1:0]    irq_type,
    input  logic [WIDTH-1:0]    irq_pol,
    input  logic [WIDTH-1:0]    irq_clr,
    output logic [WIDTH-1:0]    gpio_in_o,
    output logic [WIDTH-1:0]    irq_status_o,
    output logic                irq_o
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] level_evt;
    logic [WIDTH-1:0] evt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= i_gpio;
            s2 <= s1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        logic [DB_CNT_W-1:0] cnt;
        logic                stb;

        // A count above a freshly lowered limit is treated as reached.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (!db_en[i]) begin
                cnt <= '0;
                stb <= s2[i];
            end else if (s2[i] == stb) begin
                cnt <= '0;
            end else if (cnt >= db_limit) begin
                cnt <= '0;
                stb <= s2[i];
            end else begin
                cnt <= cnt + DB_CNT_W'(1);
            end
        end

        assign stable[i] = stb;
    end
`else
    logic unused_db;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable <= '0;
        end else begin
            stable <= s2;
        end
    end

    assign unused_db = ^{db_en, db_limit};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev <= '0;
        end else begin
            prev <= stable;
        end
    end

    assign rise      = stable & ~prev;
    assign fall      = ~stable & prev;
    assign edge_evt  = (irq_pol & rise) | (~irq_pol & fall);
    assign level_evt = (irq_pol & stable) | (~irq_pol & ~stable);
    assign evt       = ((irq_type & edge_evt) | (~irq_type & level_evt))
                       & irq_en;

    // Set has priority, so an active level keeps re-arming over a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status <= '0;
        end else begin
            status <= evt | (status & ~irq_clr);
        end
    end

    assign gpio_in_o    = stable;
    assign irq_status_o = status;
    assign irq_o        = |status;

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: vector table, latency scoreboard and corner sequences.
// Debounce sequences run only when GPIO_IN_DEBOUNCE_EN is defined.
module tb_gpio_in_cond;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pad;
    logic [23:0] db_en;
    logic [7:0]  db_limit;
    logic [23:0] irq_en;
    logic [23:0] irq_type;
    logic [23:0] irq_pol;
    logic [23:0] irq_clr;
    logic [23:0] gpio_in;
    logic [23:0] st;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] prv;
        logic [23:0] nxt;
        logic [23:0] en;
        logic [23:0] ex_in;
        logic [23:0] ex_st;
    } vec_t;

    vec_t        tv[8];
    logic [23:0] q[$];
    logic [23:0] exp_v;
    logic        seen;

    gpio_in_cond #(
        .WIDTH(24),
        .DB_CNT_W(8)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .i_gpio(pad),
        .db_en(db_en),
        .db_limit(db_limit),
        .irq_en(irq_en),
        .irq_type(irq_type),
        .irq_pol(irq_pol),
        .irq_clr(irq_clr),
        .gpio_in_o(gpio_in),
        .irq_status_o(st),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [23:0] act,
                         input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_all();
        irq_en  = '0;
        irq_clr = '1;
        tick(1);
        irq_clr = '0;
    endtask

    initial begin
        // bits 7:4 edge (7,6 rise; 5,4 fall), 3:0 level (3,2 high; 1,0 low)
        tv[0] = '{24'h00, 24'hFF, 24'hFF, 24'hFF, 24'hCF};
        tv[1] = '{24'hFF, 24'h00, 24'hFF, 24'h00, 24'h3F};
        tv[2] = '{24'h0F, 24'hF0, 24'hFF, 24'hF0, 24'hCF};
        tv[3] = '{24'hF0, 24'h0F, 24'hFF, 24'h0F, 24'h3F};
        tv[4] = '{24'h00, 24'hFF, 24'h0F, 24'hFF, 24'h0F};
        tv[5] = '{24'hFF, 24'h00, 24'hA5, 24'h00, 24'h25};
        tv[6] = '{24'hAA, 24'h55, 24'hFF, 24'h55, 24'h6F};
        tv[7] = '{24'h55, 24'h55, 24'hFF, 24'h55, 24'h06};

        rst_n    = 1'b0;
        pad      = 24'hFFFFFF;
        db_en    = '0;
        db_limit = '0;
        irq_en   = '0;
        irq_type = '0;
        irq_pol  = '0;
        irq_clr  = '0;

        // reset values and propagation of a high input at release
        tick(3);
        check("rst_in", gpio_in, 24'h0);
        check("rst_st", st, 24'h0);
        check("rst_irq", 24'(irq), 24'h0);
        rst_n = 1'b1;
        tick(1);
        check("rel_e1", gpio_in, 24'h0);
        tick(1);
        check("rel_e2", gpio_in, 24'h0);
        tick(1);
        check("rel_e3", gpio_in, 24'hFFFFFF);

        // bypass latency scoreboard: 3 edges from drive to gpio_in_o
        q.delete();
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 3) begin
                exp_v = q.pop_front();
                check("stream", gpio_in, exp_v);
            end
            pad = 24'($urandom);
            q.push_back(pad);
            tick(1);
        end
        while (q.size() > 0) begin
            exp_v = q.pop_front();
            check("stream", gpio_in, exp_v);
            tick(1);
        end

        // interrupt mode table
        irq_type = 24'hF0;
        irq_pol  = 24'hCC;
        for (int v = 0; v < 8; v++) begin
            irq_en = '0;
            pad    = tv[v].prv;
            tick(5);
            clear_all();
            irq_en = tv[v].en;
            tick(2);
            pad = tv[v].nxt;
            tick(6);
            check($sformatf("vec%0d_in", v), gpio_in, tv[v].ex_in);
            check($sformatf("vec%0d_st", v), st, tv[v].ex_st);
            check($sformatf("vec%0d_irq", v), 24'(irq),
                  24'(tv[v].ex_st != 24'h0));
        end

        // rising edge on bit 5, bypass path, then clear
        irq_en   = '0;
        irq_type = '0;
        irq_pol  = '0;
        pad      = '0;
        tick(5);
        clear_all();
        irq_type = 24'h1 << 5;
        irq_pol  = 24'h1 << 5;
        irq_en   = 24'h1 << 5;
        pad[5]   = 1'b1;
        tick(1);
        check("b5_e1", 24'(gpio_in[5]), 24'h0);
        tick(1);
        check("b5_e2", 24'(gpio_in[5]), 24'h0);
        tick(1);
        check("b5_e3", 24'(gpio_in[5]), 24'h1);
        check("b5_e3_irq", 24'(irq), 24'h0);
        tick(1);
        check("b5_e4_irq", 24'(irq), 24'h1);
        check("b5_e4_st", st, 24'h1 << 5);
        irq_clr[5] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("b5_clr_st", st, 24'h0);
        check("b5_clr_irq", 24'(irq), 24'h0);

        // level-low on bit 16: clear only sticks once level is removed
        irq_en   = '0;
        irq_type = '0;
        irq_pol  = '0;
        pad      = '0;
        tick(5);
        clear_all();
        irq_en[16] = 1'b1;
        tick(2);
        check("lvl_set", 24'(st[16]), 24'h1);
        irq_clr[16] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("lvl_held", 24'(st[16]), 24'h1);
        pad[16] = 1'b1;
        tick(4);
        irq_clr[16] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("lvl_clr", st, 24'h0);
        check("lvl_clr_irq", 24'(irq), 24'h0);

        // rising event on bit 20 coinciding with a clear: set wins
        irq_en = '0;
        pad    = '0;
        tick(5);
        clear_all();
        irq_type[20] = 1'b1;
        irq_pol[20]  = 1'b1;
        irq_en[20]   = 1'b1;
        pad[20]      = 1'b1;
        tick(3);
        check("sim_in", 24'(gpio_in[20]), 24'h1);
        irq_clr[20] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("sim_st", st, 24'h1 << 20);
        irq_clr[20] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("sim_clr", st, 24'h0);

        irq_en   = '0;
        irq_type = '0;
        irq_pol  = '0;
        pad      = '0;
        tick(5);
        clear_all();

`ifdef GPIO_IN_DEBOUNCE_EN
        // 4-cycle glitch rejected with limit 4
        db_en[0]    = 1'b1;
        db_limit    = 8'd4;
        irq_type[0] = 1'b1;
        irq_pol[0]  = 1'b1;
        irq_en[0]   = 1'b1;
        seen        = 1'b0;
        pad[0]      = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            if (e == 4) pad[0] = 1'b0;
            seen = seen | gpio_in[0];
        end
        check("glitch_in", 24'(seen), 24'h0);
        check("glitch_st", st, 24'h0);

        // 5-cycle pulse accepted on the 7th edge
        pad[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            if (e == 5) pad[0] = 1'b0;
            check($sformatf("pulse_e%0d", e), 24'(gpio_in[0]),
                  24'(e == 7));
        end
        tick(1);
        check("pulse_st", st, 24'h1);

        // async reset in the middle of a long count
        tick(10);
        check("pre_long_in", 24'(gpio_in[0]), 24'h0);
        db_limit = 8'd200;
        pad[0]   = 1'b1;
        tick(102);
        check("mid_in", 24'(gpio_in[0]), 24'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in", gpio_in, 24'h0);
        check("mid_rst_st", st, 24'h0);
        check("mid_rst_irq", 24'(irq), 24'h0);
        tick(1);
        rst_n = 1'b1;
        for (int e = 1; e <= 203; e++) begin
            tick(1);
            if (e == 202) check("long_e202", 24'(gpio_in[0]), 24'h0);
            if (e == 203) check("long_e203", 24'(gpio_in[0]), 24'h1);
        end
`else
        // debounce controls are ignored: fixed 3-edge latency
        db_en    = '1;
        db_limit = 8'd5;
        pad[3]   = 1'b1;
        tick(2);
        check("nodb_e2", 24'(gpio_in[3]), 24'h0);
        tick(1);
        check("nodb_e3", 24'(gpio_in[3]), 24'h1);
        pad[3] = 1'b0;
        tick(3);
        check("nodb_fall", 24'(gpio_in[3]), 24'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input-conditioning and interrupt stage for the GPIO block. It sits directly downstream of the IO mux and consumes the 24-bit pad input bus (`i_gpio_`). Each bit is synchronised to `clk_i`, optionally debounced, and fed into per-bit interrupt detection. The block drives the conditioned input value to the GPIO register file and a single aggregated interrupt line to the interrupt controller.

## Interface
- `WIDTH`, 24: number of GPIO bits; matches the IO mux pad bus.
- `DB_CNT_W`, 8: width of the debounce counter and of `db_limit`.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `i_gpio` in WIDTH: raw pad input from the IO mux (`i_gpio_`); asynchronous to `clk_i`.
- `db_en` in WIDTH: per-bit debounce enable.
- `db_limit` in DB_CNT_W: debounce threshold, shared by all bits.
- `irq_en` in WIDTH: per-bit interrupt enable.
- `irq_type` in WIDTH: per-bit mode; 0 = level, 1 = edge.
- `irq_pol` in WIDTH: per-bit polarity; level mode 1 = high, 0 = low; edge mode 1 = rising, 0 = falling.
- `irq_clr` in WIDTH: per-bit write-1-to-clear pulse, one cycle wide.
- `gpio_in_o` out WIDTH: conditioned (stable) input value.
- `irq_status_o` out WIDTH: sticky per-bit interrupt status.
- `irq_o` out 1: OR of all bits of `irq_status_o`.

## Operation
- **Synchroniser:** two-flop chain per bit, `s1` then `s2`.
- **Debounce, per bit, when `db_en[i]` = 1:**
  - `s2` == `stable`: counter is set to 0.
  - `s2` != `stable` and counter < `db_limit`: counter is incremented.
  - `s2` != `stable` and counter == `db_limit`: `stable` is loaded with `s2` and the counter is set to 0.
  - A pulse at `s2` lasting ≤ `db_limit` cycles is rejected.
  - `db_limit` = 0: `stable` follows `s2` with one register stage.
  - The counter saturates at `db_limit`; it never wraps.
- **Debounce bypass, when `db_en[i]` = 0:** `stable` is loaded with `s2` every cycle and the counter is held at 0.
- **Changing `db_en` or `db_limit` mid-count:** takes effect next cycle. There is no reset of `stable`. A counter above a newly lowered `db_limit` counts as "reached".
- `gpio_in_o` = `stable`.
- **Edge detect:** `prev` is `stable` delayed one cycle.
  - `rise` = `stable` & ~`prev`.
  - `fall` = ~`stable` & `prev`.
- **Event per bit:**
  - Edge mode: `irq_pol` ? `rise` : `fall`.
  - Level mode: `irq_pol` ? `stable` : ~`stable`.
- **Status update per bit:**
  - Set when event & `irq_en`.
  - Else clear when `irq_clr`.
  - Else hold.
  - Set wins over simultaneous clear.
  - A level-mode event that is still active re-sets the bit every cycle, so a clear only sticks once the level is removed.
- **Disabling `irq_en`:** does not clear status.
- **`irq_o`:** reduction OR of the status flops; no extra register.

## Timing
- **Reset values:** all flops reset to 0 (`s1`, `s2`, `stable`, `prev`, counters, status). After reset, `gpio_in_o` = 0, `irq_status_o` = 0, `irq_o` = 0.
- **Input that is high at reset release:** it propagates as a rising edge. Software enables interrupts only after that edge has settled.
- **Input latency, bypass:** a pad change set up before clock edge E reaches `gpio_in_o` after edge E+2 (three flops).
- **Input latency, debounce:** same as bypass plus `db_limit` edges, i.e. `gpio_in_o` updates after edge E+2+`db_limit`.
- **Status latency:** `irq_status_o`/`irq_o` assert one edge after `gpio_in_o` changes in edge mode, or one edge after the level condition holds in level mode.
- **Clear latency:** `irq_clr` sampled at edge C clears status after edge C.
- **Reset mid-operation:** asynchronous. All state, including in-flight counts and pending status, is discarded immediately.

## Configuration
- Macro: `GPIO_IN_DEBOUNCE_EN`.
- **Defined:** debounce counters and logic are compiled in, as described above.
- **Undefined:** no counters are instantiated. `db_en` and `db_limit` remain as ports but are ignored. Every bit behaves as `db_en` = 0, with a fixed 3-cycle input latency.

## Test plan
- **Reset values:** hold `rst_ni` = 0 with `i_gpio` = 24'hFFFFFF, then release → all outputs are 0 during reset. `gpio_in_o` = 24'hFFFFFF after the 3rd edge.
- **Rising-edge interrupt, bypass path:** `irq_type[5]`=1, `irq_pol[5]`=1, `irq_en[5]`=1, `db_en`=0; toggle bit 5 from 0 to 1 → `gpio_in_o[5]`=1 after 3 edges and `irq_o`=1 after 4. An `irq_clr[5]` pulse → `irq_status_o[5]`=0 on the next edge, `irq_o`=0.
- **Debounce filter:** `db_en[0]`=1, `db_limit`=4 (macro defined):
  - 4-cycle high glitch → `gpio_in_o[0]` stays 0 and no status is set.
  - 5-cycle pulse → `gpio_in_o[0]`=1 exactly 7 edges after the input rises.
- **Level mode:** `irq_type[16]`=0, `irq_pol[16]`=0, `irq_en[16]`=1; hold bit 16 low and pulse `irq_clr[16]` → status stays 1. Drive bit 16 high, wait 4 edges, then clear → status 0.
- **Simultaneous set and clear:** rising event on bit 20 coincides with `irq_clr[20]` → `irq_status_o[20]` = 1.
- **Reset mid-count:** `db_limit`=200; assert `rst_ni` at count 100 → counter and outputs return to 0 asynchronously, and a fresh 201-cycle pulse is required afterwards.
